// File: rtl/loader_pkg.sv
// Shared constants for the UART program loader: frame bytes, error codes and frame FSM states.
package loader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] TGT_INST  = 8'h00;
    localparam logic [7:0] TGT_DATA  = 8'h01;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TGT_LEN = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_CHK     = 2'd3;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TGT     = 3'd1;
    localparam state_t ST_LEN_LO  = 3'd2;
    localparam state_t ST_LEN_HI  = 3'd3;
    localparam state_t ST_PAYLOAD = 3'd4;
    localparam state_t ST_CHECK   = 3'd5;
    localparam state_t ST_DONE    = 3'd6;
    localparam state_t ST_ERR     = 3'd7;
endpackage

// File: rtl/uart_prog_loader_if.sv
// Loader-side bundle: serial input plus the memory write port and load status.
interface uart_prog_loader_if #(parameter int ADDR_W = 14);
    logic              rx;
    logic              cpu_hold;
    logic              inst_we;
    logic              data_we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              load_done;
    logic              load_err;
    logic [1:0]        err_code;

    modport master (
        input  rx,
        output cpu_hold, inst_we, data_we, waddr, wdata, load_done, load_err, err_code
    );

    modport slave (
        output rx,
        input  cpu_hold, inst_we, data_we, waddr, wdata, load_done, load_err, err_code
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, start-bit recheck at half bit, centre sampling.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       rstate;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rstate    <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rstate)
                RX_IDLE: begin
                    if (!rx_sync && rx_prev) begin
                        cnt    <= HALF;
                        rstate <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_sync) begin
                        cnt     <= FULL;
                        bit_idx <= '0;
                        rstate  <= RX_DATA;
                    end else begin
                        rstate <= RX_IDLE;  // low glitch, not a start bit
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        cnt     <= FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= RX_STOP;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (rx_sync) begin
                            byte_vld  <= 1'b1;
                            byte_data <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rstate <= RX_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// Frame parser that writes received 32-bit words to instruction or data memory and holds the CPU.
// state   | meaning
// IDLE    | waiting for sync byte, CPU free
// TGT     | expecting target byte
// LEN_LO  | expecting word count low byte
// LEN_HI  | expecting word count high byte, range check
// PAYLOAD | assembling words, one write strobe per 4 bytes
// CHECK   | expecting XOR checksum byte
// DONE    | load good, CPU released
// ERR     | load aborted, CPU kept in hold
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 14,
    parameter int TIMEOUT  = CLK_FREQ / 10
) (
    input logic                clk,
    input logic                rst,
    uart_prog_loader_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TMO_W        = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

    logic              byte_vld, frame_err;
    logic [7:0]        byte_data;
    state_t            state;
    logic              target_data;
    logic [7:0]        len_lo;
    logic [15:0]       len_n;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_sr;
    logic [7:0]        chk;
    logic [TMO_W-1:0]  tmo;
    logic              active;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (bus.rx),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign len_n  = {byte_data, len_lo};
    assign active = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            target_data   <= 1'b0;
            len_lo        <= '0;
            words_left    <= '0;
            widx          <= '0;
            byte_cnt      <= '0;
            asm_sr        <= '0;
            chk           <= '0;
            tmo           <= '0;
            bus.cpu_hold  <= 1'b0;
            bus.inst_we   <= 1'b0;
            bus.data_we   <= 1'b0;
            bus.waddr     <= '0;
            bus.wdata     <= '0;
            bus.load_done <= 1'b0;
            bus.load_err  <= 1'b0;
            bus.err_code  <= ERR_NONE;
        end else begin
            bus.inst_we <= 1'b0;
            bus.data_we <= 1'b0;
            if (active && frame_err) begin
                state        <= ST_ERR;
                bus.load_err <= 1'b1;
                bus.err_code <= ERR_FRAME;
            end else if (byte_vld) begin
                tmo <= TMO_LOAD;
                case (state)
                    ST_TGT: begin
                        chk         <= chk ^ byte_data;
                        target_data <= byte_data[0];
                        if (byte_data > TGT_DATA) begin
                            state        <= ST_ERR;
                            bus.load_err <= 1'b1;
                            bus.err_code <= ERR_TGT_LEN;
                        end else begin
                            state <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        chk    <= chk ^ byte_data;
                        len_lo <= byte_data;
                        state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        chk <= chk ^ byte_data;
                        if ({1'b0, len_n} > MAX_WORDS) begin
                            state        <= ST_ERR;
                            bus.load_err <= 1'b1;
                            bus.err_code <= ERR_TGT_LEN;
                        end else if (len_n == 16'd0) begin
                            state <= ST_CHECK;
                        end else begin
                            words_left <= len_n;
                            byte_cnt   <= '0;
                            state      <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        chk      <= chk ^ byte_data;
                        asm_sr   <= {byte_data, asm_sr[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bus.inst_we <= (target_data == TGT_INST[0]);
                            bus.data_we <= (target_data == TGT_DATA[0]);
                            bus.waddr   <= widx;
                            bus.wdata   <= {byte_data, asm_sr};
                            widx        <= widx + 1'b1;
                            words_left  <= words_left - 16'd1;
                            if (words_left == 16'd1) state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (byte_data == chk) begin
                            state         <= ST_DONE;
                            bus.cpu_hold  <= 1'b0;
                            bus.load_done <= 1'b1;
                        end else begin
                            state        <= ST_ERR;
                            bus.load_err <= 1'b1;
                            bus.err_code <= ERR_CHK;
                        end
                    end
                    default: begin
                        // IDLE, DONE and ERR all restart on the sync byte
                        if (byte_data == SYNC_BYTE) begin
                            state         <= ST_TGT;
                            bus.cpu_hold  <= 1'b1;
                            bus.load_done <= 1'b0;
                            bus.load_err  <= 1'b0;
                            bus.err_code  <= ERR_NONE;
                            chk           <= '0;
                            widx          <= '0;
                        end
                    end
                endcase
            end else if (active) begin
                if (tmo == '0) begin
                    state        <= ST_ERR;
                    bus.load_err <= 1'b1;
                    bus.err_code <= ERR_FRAME;
                end else begin
                    tmo <= tmo - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench: frame-level reference model, write-port scoreboard, directed and random frames.
module tb_uart_prog_loader;
    localparam int CLK_FREQ = 800_000;
    localparam int BAUD     = 100_000;
    localparam int ADDR_W   = 14;
    localparam int TIMEOUT  = 300;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_prog_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              tgt;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int                tests = 0;
    int                fails = 0;
    wr_t               exp_q[$];
    int                strobe_cnt = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [31:0]       last_wdata = '0;

    // Every strobe must match the next write the model predicted
    always @(negedge clk) begin
        wr_t e;
        if (!rst && (bus.inst_we || bus.data_we)) begin
            tests++;
            strobe_cnt++;
            last_waddr = bus.waddr;
            last_wdata = bus.wdata;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe got inst_we=%0b data_we=%0b waddr=%0d wdata=%h, required no strobe",
                         bus.inst_we, bus.data_we, bus.waddr, bus.wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.inst_we !== !e.tgt || bus.data_we !== e.tgt ||
                    bus.waddr !== e.addr || bus.wdata !== e.data) begin
                    fails++;
                    $display("FAIL write_port got inst_we=%0b data_we=%0b waddr=%0d wdata=%h, required inst_we=%0b data_we=%0b waddr=%0d wdata=%h",
                             bus.inst_we, bus.data_we, bus.waddr, bus.wdata, !e.tgt, e.tgt, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [7:0] xor_first(input logic [7:0] q[$], input int cnt);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < cnt; i++) x = x ^ q[i];
        return x;
    endfunction

    // Frame-level model: d = bytes after the sync byte that actually arrived
    task automatic model_frame(input logic [7:0] d[$], output logic done, output logic [1:0] code);
        int  n;
        int  avail;
        int  words;
        wr_t e;
        done = 1'b0;
        code = 2'd2;
        if (d.size() >= 1 && d[0] > 8'd1) begin
            code = 2'd1;
            return;
        end
        if (d.size() < 3) return;
        n = int'(d[1]) + 256 * int'(d[2]);
        if (n > 2 ** ADDR_W) begin
            code = 2'd1;
            return;
        end
        avail = d.size() - 3;
        words = (avail / 4 < n) ? avail / 4 : n;
        for (int w = 0; w < words; w++) begin
            e.tgt  = d[0][0];
            e.addr = ADDR_W'(w);
            e.data = {d[3+4*w+3], d[3+4*w+2], d[3+4*w+1], d[3+4*w]};
            exp_q.push_back(e);
        end
        if (avail >= 4 * n + 1) begin
            if (d[3+4*n] == xor_first(d, 3 + 4 * n)) begin
                done = 1'b1;
                code = 2'd0;
            end else begin
                code = 2'd3;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        if (bad_stop) repeat (2 * CPB) @(negedge clk);
        repeat ($urandom_range(1, 20)) @(negedge clk);
    endtask

    task automatic check_status(input string name, input logic hold, input logic done,
                                input logic err, input logic [1:0] code);
        check(name, 64'({bus.cpu_hold, bus.load_done, bus.load_err, bus.err_code}),
              64'({hold, done, err, code}));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("outputs_in_reset",
              64'({bus.cpu_hold, bus.inst_we, bus.data_we, bus.load_done, bus.load_err,
                   bus.err_code, bus.waddr, bus.wdata}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // abort: 0 none, 1 framing-error byte, 2 stall past timeout, 3 reset
    task automatic run_frame(input string name, input logic [7:0] fb[$], input int cut, input int abort);
        logic [7:0] d[$];
        logic       done;
        logic [1:0] code;
        for (int i = 0; i < cut; i++) d.push_back(fb[i]);
        model_frame(d, done, code);
        send_byte(8'hA5, 1'b0);
        check_status("after_sync", 1'b1, 1'b0, 1'b0, 2'd0);
        foreach (d[i]) send_byte(d[i], 1'b0);
        case (abort)
            1: send_byte(8'($urandom_range(0, 255)), 1'b1);
            2: repeat (TIMEOUT + 4 * CPB) @(negedge clk);
            3: reset_pulse();
            default: ;
        endcase
        repeat (2 * CPB) @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (abort == 3) check_status(name, 1'b0, 1'b0, 1'b0, 2'd0);
        else            check_status(name, !done, done, !done, code);
    endtask

    initial begin
        logic [7:0] f1[$];
        logic [7:0] fb[$];
        logic [7:0] b;
        int         kind, n, tgt, cut, abort;

        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("outputs_in_reset",
              64'({bus.cpu_hold, bus.inst_we, bus.data_we, bus.load_done, bus.load_err,
                   bus.err_code, bus.waddr, bus.wdata}), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Two instruction words at addresses 0 and 1
        f1 = '{8'h00, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        check("model_chk_pin", 64'(xor_first(f1, 11)), 64'h73);
        f1.push_back(8'h73);
        strobe_cnt = 0;
        run_frame("t1_status", f1, 12, 0);
        check("t1_strobes", 64'(strobe_cnt), 64'd2);
        check("t1_last_waddr", 64'(last_waddr), 64'd1);
        check("t1_last_wdata", 64'(last_wdata), 64'h00A00113);
        check_status("t1_literal", 1'b0, 1'b1, 1'b0, 2'd0);

        strobe_cnt = 0;
        run_frame("t2_empty_ok", '{8'h01, 8'h00, 8'h00, 8'h01}, 4, 0);
        run_frame("t2_empty_badchk", '{8'h01, 8'h00, 8'h00, 8'h00}, 4, 0);
        check_status("t2_literal", 1'b1, 1'b0, 1'b1, 2'd3);
        run_frame("t3_bad_target", '{8'h02}, 1, 0);
        check_status("t3_literal", 1'b1, 1'b0, 1'b1, 2'd1);
        run_frame("t3_too_long", '{8'h00, 8'h01, 8'h40}, 3, 0);
        check("t2_t3_no_strobes", 64'(strobe_cnt), 64'd0);

        run_frame("t4_framing", f1, 6, 1);
        check_status("t4_literal", 1'b1, 1'b0, 1'b1, 2'd2);
        strobe_cnt = 0;
        run_frame("t4_stall", f1, 5, 2);
        check("t4_no_partial_word", 64'(strobe_cnt), 64'd0);

        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_status("t5_noise_ignored", 1'b1, 1'b0, 1'b1, 2'd2);
        fb = '{8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        fb.push_back(xor_first(fb, 7));
        run_frame("t5_after_noise", fb, 8, 0);

        run_frame("t6_reset_mid", f1, 8, 3);
        strobe_cnt = 0;
        run_frame("t6_reload", f1, 12, 0);
        check("t6_strobes", 64'(strobe_cnt), 64'd2);

        for (int f = 0; f < 15; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, $urandom_range(0, 3) == 0);
            end
            kind = int'($urandom_range(0, 9));
            n    = int'($urandom_range(0, 4));
            tgt  = (kind == 7) ? int'($urandom_range(2, 255)) : int'($urandom_range(0, 1));
            if (kind == 7 && $urandom_range(0, 1) == 1) begin
                tgt = int'($urandom_range(0, 1));
                n   = int'($urandom_range(16385, 65535));
            end
            fb.delete();
            fb.push_back(8'(tgt));
            fb.push_back(8'(n));
            fb.push_back(8'(n >> 8));
            if (n <= 2 ** ADDR_W) begin
                for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom_range(0, 255)));
                b = xor_first(fb, fb.size());
                if (kind == 6) b = b ^ 8'($urandom_range(1, 255));
                fb.push_back(b);
            end
            cut   = fb.size();
            abort = 0;
            if (kind == 7) begin
                cut = (tgt > 1) ? 1 : 3;
            end else if (kind == 8 || kind == 9) begin
                cut   = int'($urandom_range(0, fb.size() - 1));
                abort = kind - 7;
            end
            run_frame("rand_status", fb, cut, abort);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
